// File: rtl/approx_error_monitor8.sv
// rtl/approx_error_monitor8.sv - windowed error statistics for an 8x8 approximate multiplier
// Optional MEAN_ERR_EN adds a registered mean of the window's absolute errors.
module approx_error_monitor8 #(
    parameter int LOG2_SAMPLES = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      valid_i,
    input  logic [7:0]                operand1_i,
    input  logic [7:0]                operand2_i,
    input  logic [15:0]               approx_result_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic [LOG2_SAMPLES:0]     err_count_o,
    output logic [15:0]               max_err_o,
    output logic [16+LOG2_SAMPLES-1:0] sum_err_o,
    output logic [15:0]               mean_err_o
);

    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam int SUM_W = 16 + LOG2_SAMPLES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [LOG2_SAMPLES-1:0] sample_cnt;
    logic [15:0]             exact;
    logic [15:0]             err;
    logic [SUM_W-1:0]        sum_next;
    logic                    accept;

    always_comb begin
        exact    = 16'(operand1_i) * 16'(operand2_i);
        err      = (exact >= approx_result_i) ? (exact - approx_result_i)
                                              : (approx_result_i - exact);
        sum_next = sum_err_o + SUM_W'(err);
        accept   = valid_i && (state == RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ready_o     <= 1'b0;
            done_o      <= 1'b0;
            sample_cnt  <= '0;
            err_count_o <= '0;
            max_err_o   <= '0;
            sum_err_o   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state       <= RUN;
                        ready_o     <= 1'b1;
                        done_o      <= 1'b0;
                        sample_cnt  <= '0;
                        err_count_o <= '0;
                        max_err_o   <= '0;
                        sum_err_o   <= '0;
                    end
                end
                RUN: begin
                    if (valid_i) begin
                        sum_err_o   <= sum_next;
                        err_count_o <= err_count_o + CNT_W'(err != 16'd0);
                        if (err > max_err_o)
                            max_err_o <= err;
                        sample_cnt  <= sample_cnt + 1'b1;
                        // counter wraps to zero on the final sample of the window
                        if (sample_cnt == '1) begin
                            state   <= DONE;
                            ready_o <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEAN_ERR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            mean_err_o <= '0;
        else if (start_i && (state != RUN))
            mean_err_o <= '0;
        else if (accept)
            mean_err_o <= sum_next[SUM_W-1:LOG2_SAMPLES];
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign mean_err_o    = 16'd0;
`endif

endmodule

// File: tb/tb_approx_error_monitor8.sv
// tb/tb_approx_error_monitor8.sv - table-driven bench for approx_error_monitor8 with four-sample windows
module tb_approx_error_monitor8;

    localparam int L = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    op1 = '0;
    logic [7:0]    op2 = '0;
    logic [15:0]   ap = '0;
    logic          ready;
    logic          done;
    logic [L:0]    err_count;
    logic [15:0]   max_err;
    logic [17:0]   sum_err;
    logic [15:0]   mean_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } smp_t;

    typedef struct {
        int cnt;
        int mx;
        int sm;
    } exp_t;

    smp_t smp[16];
    exp_t ex[4];

    approx_error_monitor8 #(.LOG2_SAMPLES(L)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .valid_i        (valid),
        .operand1_i     (op1),
        .operand2_i     (op2),
        .approx_result_i(ap),
        .ready_o        (ready),
        .done_o         (done),
        .err_count_o    (err_count),
        .max_err_o      (max_err),
        .sum_err_o      (sum_err),
        .mean_err_o     (mean_err)
    );

    always #5 clk = ~clk;

    function automatic int exp_mean(input int s);
`ifdef MEAN_ERR_EN
        return (s >> L) & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input smp_t s, input int gap);
        op1 = s.a; op2 = s.b; ap = s.p; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_results(input string tag, input exp_t e);
        check({tag, " done"},  32'(done), 32'd1);
        check({tag, " ready"}, 32'(ready), 32'd0);
        check({tag, " count"}, 32'(err_count), 32'(e.cnt));
        check({tag, " max"},   32'(max_err), 32'(e.mx));
        check({tag, " sum"},   32'(sum_err), 32'(e.sm));
        check({tag, " mean"},  32'(mean_err), 32'(exp_mean(e.sm)));
    endtask

    task automatic check_cleared(input string tag, input logic rdy);
        check({tag, " ready"}, 32'(ready), 32'(rdy));
        check({tag, " done"},  32'(done), 32'd0);
        check({tag, " count"}, 32'(err_count), 32'd0);
        check({tag, " max"},   32'(max_err), 32'd0);
        check({tag, " sum"},   32'(sum_err), 32'd0);
        check({tag, " mean"},  32'(mean_err), 32'd0);
    endtask

    initial begin
        // window 0: every product exact
        smp[0]  = '{8'h29, 8'h7A, 16'h138A};
        smp[1]  = '{8'h11, 8'h11, 16'h0121};
        smp[2]  = '{8'h81, 8'h1C, 16'h0E1C};
        smp[3]  = '{8'h00, 8'hFF, 16'h0000};
        ex[0]   = '{0, 0, 0};
        // window 1: errors 10, 300, 5 (approx high), 0
        smp[4]  = '{8'h10, 8'h10, 16'h00F6};
        smp[5]  = '{8'h20, 8'h20, 16'h02D4};
        smp[6]  = '{8'h03, 8'h05, 16'h0014};
        smp[7]  = '{8'h00, 8'h00, 16'h0000};
        ex[1]   = '{3, 300, 315};
        // window 2: errors 16 (approx high), 65025, 0, 2
        smp[8]  = '{8'h10, 8'h10, 16'h0110};
        smp[9]  = '{8'hFF, 8'hFF, 16'h0000};
        smp[10] = '{8'h01, 8'h01, 16'h0001};
        smp[11] = '{8'h02, 8'h03, 16'h0004};
        ex[2]   = '{3, 16'hFE01, 18'h0FE13};
        // window 3: largest possible error every sample
        for (int i = 12; i < 16; i++) smp[i] = '{8'hFF, 8'hFF, 16'h0000};
        ex[3]   = '{4, 16'hFE01, 18'h3F804};

        #2;
        check_cleared("reset", 1'b0);
        tick();
        rst = 1'b0;
        tick();

        for (int w = 0; w < 4; w++) begin
            do_start();
            check_cleared($sformatf("win%0d start", w), 1'b1);
            for (int s = 0; s < 4; s++) begin
                if (s == 3) check($sformatf("win%0d early done", w), 32'(done), 32'd0);
                send(smp[w*4+s], 0);
            end
            check_results($sformatf("win%0d", w), ex[w]);
        end

        // DONE holds results while valid_i toggles
        for (int i = 0; i < 3; i++) send(smp[4+i], 0);
        check_results("hold", ex[3]);

        // gaps of 3 cycles with a stray start pulse mid-window
        do_start();
        for (int s = 0; s < 4; s++) begin
            send(smp[4+s], 1);
            if (s == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end else begin
                tick();
            end
            tick();
            check($sformatf("gap ready %0d", s), 32'(ready), (s == 3) ? 32'd0 : 32'd1);
        end
        check_results("gap", ex[1]);

        // asynchronous reset after two samples discards the window
        do_start();
        send(smp[8], 0);
        send(smp[9], 0);
        check("mid sum", 32'(sum_err), 32'h0FE11);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("async rst", 1'b0);
        tick();
        rst = 1'b0;
        for (int s = 0; s < 4; s++) send(smp[12+s], 0);
        check_cleared("no start", 1'b0);
        do_start();
        for (int s = 0; s < 4; s++) send(smp[4+s], 0);
        check_results("post rst", ex[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/approx_error_monitor8.md
APPROX_ERROR_MONITOR8 -- requirements
Module: approx_error_monitor8

Interface
REQ-001 SHALL have parameter LOG2_SAMPLES, default 8, log2 of samples per measurement window (range 1..12).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  begin a new measurement window.
REQ-005 SHALL have port valid_i  input  1  sample present on operand/approx inputs this cycle.
REQ-006 SHALL have port operand1_i  input  8  multiplicand fed to the approximate multiplier.
REQ-007 SHALL have port operand2_i  input  8  multiplier operand fed to the approximate multiplier.
REQ-008 SHALL have port approx_result_i  input  16  product from the downstream-connected approximate multiplier.
REQ-009 SHALL have port ready_o  output  1  high in RUN; samples are accepted only when valid_i and ready_o are both high.
REQ-010 SHALL have port done_o  output  1  high in DONE; results valid.
REQ-011 SHALL have port err_count_o  output  LOG2_SAMPLES+1  number of samples with nonzero error.
REQ-012 SHALL have port max_err_o  output  16  largest absolute error in window.
REQ-013 SHALL have port sum_err_o  output  16+LOG2_SAMPLES  sum of absolute errors.
REQ-014 SHALL have port mean_err_o  output  16  mean absolute error (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start_i -> RUN; accumulators, max and sample counter cleared on the same edge.
REQ-017 RUN: each accepted sample updates statistics on the accepting edge; the sample counter increments.
REQ-018 exact product SHALL be the full 16-bit unsigned operand1_i*operand2_i; err = |exact - approx_result_i|, 16-bit unsigned.
REQ-019 per sample: sum += err; max = max(max, err); err_count += (err != 0).
REQ-020 sum width 16+LOG2_SAMPLES SHALL be sufficient for no overflow; no saturation logic.
REQ-021 RUN -> DONE on the edge accepting sample number 2^LOG2_SAMPLES; done_o high from the following cycle.
REQ-022 start_i in RUN SHALL be ignored; valid_i outside RUN SHALL be ignored.
REQ-023 DONE: outputs held stable; start_i -> RUN with clear (restart), and done_o low the next cycle.
REQ-024 valid_i low in RUN: no state change (gaps allowed, no timeout).
REQ-025 all outputs SHALL be registered or decoded from registered state only; no combinational input-to-output path.

Reset
REQ-026 rst_i high SHALL immediately force IDLE, ready_o=0, done_o=0, and all counters, accumulators and results to 0.
REQ-027 reset mid-RUN SHALL discard the partial window; a new start_i is required after release.

Configuration
REQ-028 macro MEAN_ERR_EN defined: mean_err_o = sum_err_o >> LOG2_SAMPLES (truncated, lower 16 bits), registered, updated with the sum.
REQ-029 MEAN_ERR_EN undefined: no mean logic; mean_err_o tied to 0.

Verification (LOG2_SAMPLES=2, four samples per window)
REQ-030 exact window: start; samples 29*7A approx 138A, 11*11 approx 0121, 81*1C approx 0E1C, 00*FF approx 0000 -> done_o, err_count 0, max 0, sum 0, mean 0.
REQ-031 mixed errors 10, 300, 5, 0 -> err_count 3, max_err 300 (012C), sum 315 (013B), mean 78 (004E) with MEAN_ERR_EN, else 0.
REQ-032 approx above exact: 10*10 approx 0110 -> err 16 counted (absolute value), contributes 0010 to sum.
REQ-033 valid_i gaps of 3 cycles between samples and start_i pulsed mid-RUN -> identical results to the gap-free run; window not restarted.
REQ-034 rst_i asserted after 2 samples -> all outputs 0 immediately; post-reset valid_i ignored until start_i; restart from DONE clears prior results.
